// File: rtl/inv_share_arb_pkg.sv
// -----------------------------------------------------------------------------
// inv_share_arb_pkg
//   Shared types and helpers for the inv_share_arb shared-inverter arbiter.
//   Contents:
//     state_t   - result buffer state {EMPTY, FULL}
//     DEF_N/W   - default requester count and operand width
//     idw_f     - requester-id width for a given requester count
//     rr_next   - behavioural round-robin pick, usable by reference models
// -----------------------------------------------------------------------------
package inv_share_arb_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   localparam int DEF_N = 4;
   localparam int DEF_W = 8;

   function automatic int idw_f(input int n);
      return $clog2(n);
   endfunction

   // Returns the first requester set in req, searching last+1, last+2, ...
   // with wrap-around over n requesters; -1 when nothing is requested.
   function automatic int rr_next(input logic [15:0] req, input int last, input int n);
      for (int off = 1; off <= n; off++) begin
         int cand;
         cand = (last + off) % n;
         if (req[cand]) return cand;
      end
      return -1;
   endfunction

endpackage

// File: rtl/inv_share_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin priority picker. Finds the first set request
//   bit after position 'last', wrapping modulo N. Nothing is granted while
//   en is low.
//   Ports:
//     req  [N]   in   request levels
//     last [IDW] in   index granted most recently (search starts after it)
//     en         in   permission to grant this cycle
//     gnt  [N]   out  one-hot grant (all zero when nothing is granted)
//     idx  [IDW] out  index of the granted requester (0 when none)
//     any        out  a grant is being issued
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] last,
   input  logic           en,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] idx,
   output logic           any
);

   // One extra bit holds last+off before the modulo-N fold.
   logic [IDW:0]   cand;
   logic [IDW-1:0] sel;

   // NOTE: every signal written here gets a default first, so no path
   // through the loop can leave one unassigned and infer a latch.
   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      sel  = '0;
      for (int off = 1; off <= N; off++) begin
         cand = {1'b0, last} + (IDW+1)'(off);
         if (cand >= (IDW+1)'(N)) cand = cand - (IDW+1)'(N);
         sel = cand[IDW-1:0];
         if (en && !any && req[sel]) begin
            any      = 1'b1;
            gnt[sel] = 1'b1;
            idx      = sel;
         end
      end
   end

endmodule

// File: rtl/inv_share_arb.sv
// -----------------------------------------------------------------------------
// inv_share_arb
//   Round-robin arbiter feeding one shared bitwise inverter (y = ~a). One
//   requester is granted per cycle; its inverted operand lands in a
//   single-entry registered output buffer with valid/ready handshake.
//   Optional macro INV_SHARE_ARB_BYPASS_EN adds a per-requester bypass that
//   passes the operand through uninverted and reports it on out_bypass.
//   Ports:
//     clk, rst_n          clock (rising edge), async active-low reset
//     req       [N]       request levels, bit i = requester i
//     req_data  [N*W]     operands, slice [i*W +: W] = requester i
//     gnt       [N]       combinational one-hot grant
//     out_valid           result buffer holds a result
//     out_ready           downstream accepts when out_valid && out_ready
//     out_data  [W]       result of the granted requester
//     out_id    [IDW]     requester that produced out_data
//     busy                mirror of out_valid
//     req_bypass [N]      (bypass build) skip inversion for requester i
//     out_bypass          (bypass build) result was passed through
// -----------------------------------------------------------------------------
module inv_share_arb
   import inv_share_arb_pkg::*;
#(
   parameter  int N   = DEF_N,
   parameter  int W   = DEF_W,
   localparam int IDW = idw_f(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] req_data,
   output logic [N-1:0]   gnt,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_data,
   output logic [IDW-1:0] out_id,
`ifdef INV_SHARE_ARB_BYPASS_EN
   input  logic [N-1:0]   req_bypass,
   output logic           out_bypass,
`endif
   output logic           busy
);

   state_t         state_q, state_d;
   logic [IDW-1:0] last_q, last_d;
   logic [IDW-1:0] id_q, id_d;
   logic [W-1:0]   data_q, data_d;
   logic           buf_free;
   logic           pick_en;
   logic           pick_any;
   logic [IDW-1:0] pick_idx;
   logic [N-1:0]   pick_gnt;
   logic [W-1:0]   sel_op;
   logic           sel_byp;
`ifdef INV_SHARE_ARB_BYPASS_EN
   logic           byp_q, byp_d;
`endif

   // The buffer can take a new result when empty, or when the held one
   // leaves this same cycle. Gating with rst_n keeps gnt low during reset.
   assign buf_free = (state_q == EMPTY) || out_ready;
   assign pick_en  = buf_free && rst_n;

   rr_pick #(
      .N   (N),
      .IDW (IDW)
   ) u_pick (
      .req  (req),
      .last (last_q),
      .en   (pick_en),
      .gnt  (pick_gnt),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   assign gnt = pick_gnt;

   // One-hot AND-OR mux of the granted operand (and its bypass flag).
   always_comb begin
      sel_op  = '0;
      sel_byp = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (pick_gnt[i]) begin
            sel_op = sel_op | req_data[i*W +: W];
`ifdef INV_SHARE_ARB_BYPASS_EN
            sel_byp = sel_byp | req_bypass[i];
`endif
         end
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      id_d    = id_q;
      data_d  = data_q;
`ifdef INV_SHARE_ARB_BYPASS_EN
      byp_d   = byp_q;
`endif
      if (pick_any) begin
         data_d  = sel_byp ? sel_op : ~sel_op;
         id_d    = pick_idx;
         last_d  = pick_idx;
         state_d = FULL;
`ifdef INV_SHARE_ARB_BYPASS_EN
         byp_d   = sel_byp;
`endif
      end else if (state_q == FULL && out_ready) begin
         // Result drained with nothing to replace it; data/id are left as-is
         // so out_data only ever moves on a capture.
         state_d = EMPTY;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   // NOTE: the result register is reset too: a single W-bit word, and it
   // gives out_data a defined value before the first capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         last_q  <= IDW'(N-1);
         id_q    <= '0;
         data_q  <= '0;
`ifdef INV_SHARE_ARB_BYPASS_EN
         byp_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         data_q  <= data_d;
`ifdef INV_SHARE_ARB_BYPASS_EN
         byp_q   <= byp_d;
`endif
      end
   end

   assign out_valid = (state_q == FULL);
   assign busy      = out_valid;
   assign out_data  = data_q;
   assign out_id    = id_q;
`ifdef INV_SHARE_ARB_BYPASS_EN
   assign out_bypass = byp_q;
`endif

endmodule

// File: tb/tb_inv_share_arb.sv
// -----------------------------------------------------------------------------
// tb_inv_share_arb
//   Directed self-checking bench for inv_share_arb with N=4, W=8.
// -----------------------------------------------------------------------------
module tb_inv_share_arb;
   import inv_share_arb_pkg::*;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int IDW = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] req_data = '0;
   logic [N-1:0]   gnt;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [W-1:0]   out_data;
   logic [IDW-1:0] out_id;
   logic           busy;
`ifdef INV_SHARE_ARB_BYPASS_EN
   logic [N-1:0]   req_bypass = '0;
   logic           out_bypass;
`endif

   int total = 0;
   int bad   = 0;

   inv_share_arb #(.N(N), .W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .req_data   (req_data),
      .gnt        (gnt),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_id     (out_id),
`ifdef INV_SHARE_ARB_BYPASS_EN
      .req_bypass (req_bypass),
      .out_bypass (out_bypass),
`endif
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input logic [7:0] d0, d1, d2, d3);
      req_data = {d3, d2, d1, d0};
   endtask

   initial begin
      int id_exp [5] = '{0, 1, 2, 3, 0};
      logic [N-1:0] pend;
      int wait_cnt [N];
      int max_wait;
      int last_m;
      int k;

      // ---- reset state, with requests already pending ----
      req = 4'b1111;
      set_data(8'h0F, 8'h0F, 8'h0F, 8'h0F);
      #2;
      check("rst_gnt", gnt, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_id", out_id, 0);
      check("rst_busy", busy, 0);
      #10;
      rst_n = 1'b1;
      #1;

      // ---- reset priority: 0,1,2,3,0 ----
      for (int i = 0; i < 5; i++) begin
         check("rr_gnt", gnt, 64'(1) << id_exp[i]);
         tick();
         check("rr_valid", out_valid, 1);
         check("rr_data", out_data, 8'hF0);
         check("rr_id", out_id, id_exp[i]);
      end

      // ---- backpressure: hold result of requester 1 ----
      set_data(8'h0F, 8'h11, 8'h22, 8'hA5);
      req = 4'b0010;
      #1;
      check("bp_gnt1", gnt, 4'b0010);
      tick();
      check("bp_id1", out_id, 1);
      check("bp_data1", out_data, 8'hEE);
      out_ready = 1'b0;
      req = 4'b0110;
      #1;
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_gnt", gnt, 0);
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_id", out_id, 1);
         check("bp_hold_data", out_data, 8'hEE);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("bp_gnt2", gnt, 4'b0100);
      tick();
      check("bp_id2", out_id, 2);
      check("bp_data2", out_data, 8'hDD);
      req = 4'b0000;
      #1;
      check("drain_gnt", gnt, 0);
      tick();
      check("drain_valid", out_valid, 0);
      check("drain_busy", busy, 0);
      check("drain_data_stable", out_data, 8'hDD);

      // ---- single requester 3, wrap-around ----
      req = 4'b1000;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("single_gnt", gnt, 4'b1000);
         tick();
         check("single_valid", out_valid, 1);
         check("single_id", out_id, 3);
         check("single_data", out_data, 8'h5A);
      end

      // ---- fairness: req[0] always high, others random but held until granted ----
      last_m = 3;
      pend = 4'b0001;
      max_wait = 0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         for (int i = 1; i < N; i++)
            if (!pend[i]) pend[i] = 1'($urandom_range(0, 1));
         req = pend;
         #1;
         k = rr_next(16'(req), last_m, N);
         check("fair_gnt", gnt, 64'(1) << k);
         for (int i = 0; i < N; i++) begin
            if (req[i] && !gnt[i]) wait_cnt[i]++;
            else wait_cnt[i] = 0;
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
         end
         tick();
         check("fair_id", out_id, k);
         last_m = k;
         if (k > 0) pend[k] = 1'($urandom_range(0, 1));
      end
      check("fair_bound", max_wait < N, 1);

      // ---- async reset mid-operation ----
      req = 4'b1111;
      check("ar_pre_valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid", out_valid, 0);
      check("ar_gnt", gnt, 0);
      check("ar_id", out_id, 0);
      check("ar_data", out_data, 0);
      req = 4'b1000;
      #3;
      rst_n = 1'b1;
      #1;
      check("ar_gnt3", gnt, 4'b1000);
      tick();
      check("ar_id3", out_id, 3);
      check("ar_data3", out_data, 8'h5A);
      rst_n = 1'b0;
      #1;
      req = 4'b1001;
      rst_n = 1'b1;
      #1;
      check("ar_gnt0", gnt, 4'b0001);
      tick();
      check("ar_id0", out_id, 0);
      check("ar_data0", out_data, 8'hF0);

`ifdef INV_SHARE_ARB_BYPASS_EN
      // ---- bypass ----
      set_data(8'h0F, 8'h3C, 8'h22, 8'hA5);
      req = 4'b0010;
      req_bypass = 4'b0010;
      #1;
      check("byp_gnt", gnt, 4'b0010);
      tick();
      check("byp_data", out_data, 8'h3C);
      check("byp_flag", out_bypass, 1);
      req = 4'b0000;
      tick();
      req = 4'b0010;
      req_bypass = 4'b0000;
      tick();
      check("nobyp_data", out_data, 8'hC3);
      check("nobyp_flag", out_bypass, 0);
`endif

      req = 4'b0000;
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
